// File: rtl/serial_sub4.sv
// rtl/serial_sub4.sv - bit-serial subtractor, one full-subtractor cell plus borrow flop
// Outputs are registered one cycle behind the FSM state, so busy/done/d/bo lag the state register.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             diff_bit;
    logic             borrow_nxt;
    logic             last_bit;

    assign diff_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand/result shifting: the difference bit enters at the MSB so bit 0 lands at r_q[0].
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        br_d  = br_q;
        cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = A;
                    b_d   = B;
                    br_d  = bi;
                    r_d   = '0;
                    cnt_d = '0;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {diff_bit, r_q[WIDTH-1:1]};
                br_d  = borrow_nxt;
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = (state_q == S_SHIFT);
        done_d = (state_q == S_DONE);
        d_d    = d_q;
        bo_d   = bo_q;
        if (state_q == S_DONE) begin
            d_d  = r_q;
            bo_d = br_q;
        end
    end

    assign d    = d_q;
    assign bo   = bo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_sub4.sv
// tb/tb_serial_sub4.sv - self-checking bench for serial_sub4
module tb_serial_sub4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       bi;
    logic [3:0] d;
    logic       bo;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    serial_sub4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .bi    (bi),
        .d     (d),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bi;
        logic [3:0] exp_d;
        logic       exp_bo;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic c);
        int r;
        r = int'(a) - int'(b) - int'(c);
        return 5'(r + 32);
    endfunction

    // Runs one operation from IDLE and checks the handshake timing along the way.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                         output logic [3:0] od, output logic obo);
        logic [3:0] d_before;
        logic       bo_before;
        logic       timing_ok;
        d_before  = d;
        bo_before = bo;
        timing_ok = 1'b1;
        A = a; B = b; bi = c; start = 1'b1;
        step();
        start = 1'b0;
        A = 4'($urandom); B = 4'($urandom); bi = 1'($urandom);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (busy !== (i <= 4)) timing_ok = 1'b0;
            if (done !== (i == 5)) timing_ok = 1'b0;
            if (i <= 4 && (d !== d_before || bo !== bo_before)) timing_ok = 1'b0;
        end
        od  = d;
        obo = bo;
        step();
        if (done !== 1'b0 || busy !== 1'b0) timing_ok = 1'b0;
        if (d !== od || bo !== obo) timing_ok = 1'b0;
        check("handshake_timing", 32'(timing_ok), 32'd1);
    endtask

    initial begin
        logic [3:0] rd;
        logic       rbo;
        logic [4:0] exp5;
        int         ndone;
        int         first_t;
        int         last_t;
        int         gap_ok;
        logic       hold_ok;

        vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0};
        vecs[1] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
        vecs[3] = '{4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0};
        vecs[4] = '{4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0};
        vecs[5] = '{4'b0111, 4'b0010, 1'b1, 4'b0100, 1'b0};
        vecs[6] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; bi = 1'b0;
        #12;
        check("reset_d", 32'(d), 32'd0);
        check("reset_bo", 32'(bo), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, rd, rbo);
            check($sformatf("vec%0d_d", i), 32'(rd), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_bo", i), 32'(rbo), 32'(vecs[i].exp_bo));
        end

        // start pulses during SHIFT and DONE must be ignored
        ndone = 0;
        A = 4'b1111; B = 4'b0001; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done) ndone++;
            if (i == 1 || i == 4) begin
                A = 4'b0000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ignore_start_ndone", 32'(ndone), 32'd1);
        check("ignore_start_d", 32'(d), 32'b1110);
        check("ignore_start_bo", 32'(bo), 32'd0);

        // asynchronous reset mid-SHIFT
        do_op(4'b0101, 4'b0011, 1'b0, rd, rbo);
        check("pre_reset_d", 32'(rd), 32'b0010);
        A = 4'b1000; B = 4'b0001; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_d", 32'(d), 32'd0);
        check("abort_bo", 32'(bo), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op(4'b1001, 4'b1001, 1'b0, rd, rbo);
        check("post_reset_d", 32'(rd), 32'd0);
        check("post_reset_bo", 32'(rbo), 32'd0);

        // start held high: results every WIDTH+2 cycles, d stable between pulses
        ndone = 0; first_t = -1; last_t = -1; gap_ok = 1; hold_ok = 1'b1;
        A = 4'b0111; B = 4'b0010; bi = 1'b1; start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (done) begin
                if (last_t >= 0 && (t - last_t) != 6) gap_ok = 0;
                if (first_t < 0) first_t = t;
                last_t = t;
                ndone++;
            end
            if (first_t >= 0 && (d !== 4'b0100 || bo !== 1'b0)) hold_ok = 1'b0;
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("b2b_first_done", 32'(first_t), 32'd6);
        check("b2b_ndone", 32'(ndone), 32'd3);
        check("b2b_spacing", 32'(gap_ok), 32'd1);
        check("b2b_hold", 32'(hold_ok), 32'd1);

        for (int k = 0; k < 512; k++) begin
            logic [3:0] xa;
            logic [3:0] xb;
            logic       xc;
            xa = 4'(k);
            xb = 4'(k >> 4);
            xc = 1'(k >> 8);
            do_op(xa, xb, xc, rd, rbo);
            exp5 = ref_sub(xa, xb, xc);
            check($sformatf("sweep_%0h_%0h_%0d", xa, xb, xc), 32'({rbo, rd}), 32'(exp5));
        end

        for (int k = 0; k < 60; k++) begin
            logic [3:0] xa;
            logic [3:0] xb;
            logic       xc;
            xa = 4'($urandom);
            xb = 4'($urandom);
            xc = 1'($urandom);
            do_op(xa, xb, xc, rd, rbo);
            exp5 = ref_sub(xa, xb, xc);
            check($sformatf("rand_%0h_%0h_%0d", xa, xb, xc), 32'({rbo, rd}), 32'(exp5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
